// File: rtl/arm_decoder.sv
// arm_decoder: registered Op/Funct/Rd decode into single-cycle ARM datapath controls.
// Define DECODER_CMP_EN to decode cmd 1010 as CMP (SUB with NoWrite); otherwise it is unsupported.
module arm_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       MemtoReg,
    output logic       ALUSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic       NoWrite
);
    logic [9:0] controls;
    logic [1:0] regSrcD, immSrcD, aluCtlD, flagWD;
    logic       aluSrcD, memtoRegD, regWD, memWD, branchD, aluOp;
    logic [3:0] cmd;
    logic       isCmp, supported, noWriteD, pcsD;

    assign cmd = Funct[4:1];
`ifdef DECODER_CMP_EN
    assign isCmp = (cmd == 4'b1010);
`else
    assign isCmp = 1'b0;
`endif

    // {RegSrc, ImmSrc, ALUSrc, MemtoReg, RegW, MemW, Branch, ALUOp}
    always_comb begin
        controls = (Op == 2'b00) ? {4'b0000, Funct[5], 5'b01001} :
                   (Op == 2'b01) ? (Funct[0] ? 10'b0001111000 : 10'b1001100100) :
                   (Op == 2'b10) ? 10'b0110100010 : 10'b0;
        {regSrcD, immSrcD, aluSrcD, memtoRegD, regWD, memWD, branchD, aluOp} = controls;
        aluCtlD = (cmd == 4'b0010 || isCmp) ? 2'b01 :
                  (cmd == 4'b0000)          ? 2'b10 :
                  (cmd == 4'b1100)          ? 2'b11 : 2'b00;
        supported = aluOp && (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 ||
                              cmd == 4'b1100 || isCmp);
        aluCtlD  = supported ? aluCtlD : 2'b00;
        flagWD   = supported ? {Funct[0], Funct[0] & ~aluCtlD[1]} : 2'b00;
        noWriteD = supported & isCmp;
        pcsD     = ((Rd == 4'hF) & regWD) | branchD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            FlagW      <= 2'b00;
            PCS        <= 1'b0;
            RegW       <= 1'b0;
            MemW       <= 1'b0;
            MemtoReg   <= 1'b0;
            ALUSrc     <= 1'b0;
            ImmSrc     <= 2'b00;
            RegSrc     <= 2'b00;
            ALUControl <= 2'b00;
            NoWrite    <= 1'b0;
        end else begin
            FlagW      <= flagWD;
            PCS        <= pcsD;
            RegW       <= regWD;
            MemW       <= memWD;
            MemtoReg   <= memtoRegD;
            ALUSrc     <= aluSrcD;
            ImmSrc     <= immSrcD;
            RegSrc     <= regSrcD;
            ALUControl <= aluCtlD;
            NoWrite    <= noWriteD;
        end
    end
endmodule

// File: tb/tb_arm_decoder.sv
// tb_arm_decoder: directed vectors with hand-computed expectations for arm_decoder.
module tb_arm_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b100101;
    logic [3:0] Rd = 4'h0;
    logic [1:0] FlagW, ImmSrc, RegSrc, ALUControl;
    logic       PCS, RegW, MemW, MemtoReg, ALUSrc, NoWrite;
    logic [13:0] outs;
    int testsRun = 0;
    int testsFailed = 0;

    arm_decoder dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .MemtoReg(MemtoReg),
        .ALUSrc(ALUSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .NoWrite(NoWrite)
    );

    always #5 clk = ~clk;

    assign outs = {RegSrc, ImmSrc, ALUSrc, MemtoReg, RegW, MemW, PCS, ALUControl, FlagW, NoWrite};

    function automatic logic [13:0] ex(input logic [1:0] rs, input logic [1:0] is,
                                       input logic as, input logic mr, input logic rw,
                                       input logic mw, input logic pc, input logic [1:0] ac,
                                       input logic [1:0] fw, input logic nw);
        return {rs, is, as, mr, rw, mw, pc, ac, fw, nw};
    endfunction

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %b expected %b (RegSrc,ImmSrc,ALUSrc,MemtoReg,RegW,MemW,PCS,ALUCtl,FlagW,NoWrite)",
                     tag, got, exp);
        end
    endtask

    task automatic apply(input string tag, input logic [1:0] op, input logic [5:0] f,
                         input logic [3:0] rd, input logic [13:0] exp);
        Op = op; Funct = f; Rd = rd;
        @(posedge clk); #1;
        check(tag, outs, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check("reset_hold", outs, 14'b0);
        @(negedge clk) reset = 1'b1;
        #1 check("release_no_edge", outs, 14'b0);
        // Funct 100101: I=1, cmd 0010 (SUB), S=1
        @(posedge clk); #1;
        check("first_capture_sub_s", outs, ex(2'b00, 2'b00, 1, 0, 1, 0, 0, 2'b01, 2'b11, 0));
        apply("orr_reg", 2'b00, 6'b011000, 4'd1, ex(2'b00, 2'b00, 0, 0, 1, 0, 0, 2'b11, 2'b00, 0));
`ifdef DECODER_CMP_EN
        apply("cmp_s", 2'b00, 6'b010101, 4'd0, ex(2'b00, 2'b00, 0, 0, 1, 0, 0, 2'b01, 2'b11, 1));
`else
        apply("cmp_s", 2'b00, 6'b010101, 4'd0, ex(2'b00, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0));
`endif
        apply("ldr", 2'b01, 6'b011001, 4'd2, ex(2'b00, 2'b01, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0));
        apply("str", 2'b01, 6'b011000, 4'd2, ex(2'b10, 2'b01, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0));
        apply("branch", 2'b10, 6'b111111, 4'd0, ex(2'b01, 2'b10, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0));
        apply("add_pc", 2'b00, 6'b001000, 4'd15, ex(2'b00, 2'b00, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0));
        apply("op11", 2'b11, 6'b111111, 4'd15, 14'b0);
        apply("bad_cmd_s", 2'b00, 6'b001111, 4'd3, ex(2'b00, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0));
        apply("and_imm_s", 2'b00, 6'b100001, 4'd4, ex(2'b00, 2'b00, 1, 0, 1, 0, 0, 2'b10, 2'b10, 0));
        apply("add_s", 2'b00, 6'b001001, 4'd5, ex(2'b00, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b11, 0));
        apply("orr_imm_s", 2'b00, 6'b111001, 4'd6, ex(2'b00, 2'b00, 1, 0, 1, 0, 0, 2'b11, 2'b10, 0));
        apply("ldr_pc", 2'b01, 6'b011001, 4'd15, ex(2'b00, 2'b01, 1, 1, 1, 0, 1, 2'b00, 2'b00, 0));
        apply("str_rd15", 2'b01, 6'b011000, 4'd15, ex(2'b10, 2'b01, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0));
        // Mid-cycle input change must not reach outputs before the next edge
        Op = 2'b11; Funct = 6'b0; Rd = 4'd0;
        #3 check("mid_cycle_hold", outs, ex(2'b10, 2'b01, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0));
        apply("sub_reg", 2'b00, 6'b000100, 4'd7, ex(2'b00, 2'b00, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0));
        reset = 1'b0;
        #1 check("async_reset", outs, 14'b0);
        @(negedge clk) reset = 1'b1;
        #1 check("post_reset_lost", outs, 14'b0);
        @(posedge clk); #1;
        check("post_reset_capture", outs, ex(2'b00, 2'b00, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0));
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
